// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state type, constants and ratio clamp for clock_divider_prog
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int unsigned MIN_RATIO = 2;

  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
    return (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
  endfunction

endpackage

// File: rtl/clkdiv_halfcycle.sv
// rtl/clkdiv_halfcycle.sv - negedge duty-correction stage giving 50% duty for odd ratios
// Used only when CLKDIV_ODD_DUTY50_EN is defined.
module clkdiv_halfcycle (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic odd_i,
  input  logic clk_pos_i,
  output logic clk_o
);

  logic neg_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_pos_i;
    end
  end

  // Delaying the rising edge by half a clk trims the odd-N high time to N/2.
  assign clk_o = odd_i ? (clk_pos_i & neg_q) : clk_pos_i;

endmodule

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable integer clock divider with glitch-free ratio changes
// Optional CLKDIV_ODD_DUTY50_EN adds a negedge stage for 50% duty at odd ratios.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RST_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             clk_pos_q, clk_pos_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             load;
  logic [CNT_W-1:0] clamped;
  logic [CNT_W:0]   half_d;

  assign wrap    = (cnt_q == ratio_q - ONE);
  assign clamped = CNT_W'(clamp_ratio(32'(div_ratio)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ratio_d       = ratio_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        load  = shadow_full_q;
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        load  = wrap && shadow_full_q;
        if (!en) state_d = STOPPING;
      end
      STOPPING: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        load  = wrap && shadow_full_q;
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Shadow only ever moves into the active ratio where cnt restarts at 0.
    if (load) begin
      ratio_d       = shadow_q;
      shadow_full_d = 1'b0;
    end

    if (cfg_valid && !shadow_full_q) begin
      shadow_d      = clamped;
      shadow_full_d = 1'b1;
    end
  end

  // Outputs are decoded from next-state values so they register in step with cnt.
  assign half_d    = ({1'b0, ratio_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  assign clk_pos_d = (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
  assign tick_d    = (state_d != IDLE) && (cnt_d == ratio_d - ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ratio_q       <= CNT_W'(RST_RATIO);
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      clk_pos_q     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ratio_q       <= ratio_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      clk_pos_q     <= clk_pos_d;
      tick_q        <= tick_d;
    end
  end

  assign cfg_ready = !shadow_full_q;
  assign tick      = tick_q;
  assign cur_ratio = ratio_q;
  assign busy      = (state_q != IDLE);

`ifdef CLKDIV_ODD_DUTY50_EN
  clkdiv_halfcycle u_halfcycle (
    .clk_i     (clk),
    .rst_ni    (rst),
    .odd_i     (ratio_q[0]),
    .clk_pos_i (clk_pos_q),
    .clk_o     (clk_out)
  );
`else
  assign clk_out = clk_pos_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - randomized self-checking bench for clock_divider_prog against a period-level model
module tb_clock_divider_prog;

  localparam int CNT_W     = 8;
  localparam int RST_RATIO = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] div_ratio = '0;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_ratio;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model: whether a period train is active, position inside the current period,
  // ratio in effect, a pending stop request and a pending ratio.
  bit m_active;
  bit m_stop;
  bit m_pend;
  int m_n;
  int m_pos;
  int m_pend_val;

  always #5 clk = ~clk;

  clock_divider_prog #(
    .CNT_W     (CNT_W),
    .RST_RATIO (RST_RATIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .div_ratio (div_ratio),
    .clk_out   (clk_out),
    .tick      (tick),
    .cur_ratio (cur_ratio),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_stop   = 0;
    m_pend   = 0;
    m_n      = RST_RATIO;
    m_pos    = 0;
  endtask

  task automatic model_edge(input bit e, input bit accept, input int val);
    bit boundary;
    if (!m_active) begin
      if (m_pend) begin
        m_n    = m_pend_val;
        m_pend = 0;
      end
      if (e) begin
        m_active = 1;
        m_pos    = 0;
        m_stop   = 0;
      end
    end else begin
      boundary = (m_pos == m_n - 1);
      m_pos = boundary ? 0 : m_pos + 1;
      if (boundary && m_pend) begin
        m_n    = m_pend_val;
        m_pend = 0;
      end
      if (boundary && m_stop && !e) begin
        m_active = 0;
        m_pos    = 0;
      end
      m_stop = !e;
    end
    if (accept) begin
      m_pend     = 1;
      m_pend_val = (val < 2) ? 2 : val;
    end
  endtask

  task automatic check_outputs();
    check("clk_out",   32'(clk_out),   32'(m_active && (m_pos < (m_n + 1) / 2)));
    check("tick",      32'(tick),      32'(m_active && (m_pos == m_n - 1)));
    check("busy",      32'(busy),      32'(m_active));
    check("cur_ratio", 32'(cur_ratio), 32'(m_n));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
  endtask

  task automatic step(input bit e, input bit cv, input int val);
    bit acc;
    @(negedge clk);
    en        = e;
    cfg_valid = cv;
    div_ratio = val[CNT_W-1:0];
    acc = cv && !m_pend;
    @(posedge clk);
    model_edge(e, acc, val);
    #1;
    check_outputs();
  endtask

  task automatic run_until_pos(input int pos);
    int guard = 0;
    while (m_pos != pos && guard < 300) begin
      step(1, 0, 0);
      guard++;
    end
    check("reach_pos", 32'(m_pos), 32'(pos));
  endtask

  initial begin
    int mode_en;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Default ratio 2 toggling.
    repeat (3) step(0, 0, 0);
    repeat (8) step(1, 0, 0);
    repeat (6) step(0, 0, 0);

    // Program 5 while idle, then run.
    step(0, 1, 5);
    repeat (2) step(0, 0, 0);
    repeat (16) step(1, 0, 0);

    // Ratio change mid-period: 4 -> 6 accepted at cnt=1.
    step(0, 0, 0);
    repeat (12) step(0, 0, 0);
    step(0, 1, 4);
    step(1, 0, 0);
    run_until_pos(1);
    step(1, 1, 6);
    repeat (16) step(1, 0, 0);

    // Stop at cnt=2 with N=8, then re-raise at cnt=5.
    step(1, 1, 8);
    repeat (10) step(1, 0, 0);
    run_until_pos(2);
    repeat (10) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    run_until_pos(2);
    repeat (3) step(0, 0, 0);
    repeat (12) step(1, 0, 0);

    // Clamping of 1 and 0.
    repeat (10) step(0, 0, 0);
    step(0, 1, 1);
    repeat (2) step(0, 0, 0);
    repeat (6) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 0);
    repeat (6) step(1, 0, 0);

    // Asynchronous reset mid-period with N=6 and a pending ratio.
    step(1, 1, 6);
    repeat (4) step(1, 0, 0);
    run_until_pos(3);
    step(1, 1, 9);
    #2;
    rst = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    mode_en = 1;
    for (int i = 0; i < 2500; i++) begin
      int v;
      if ($urandom_range(0, 39) == 0) mode_en = !mode_en;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 9));
      step(mode_en ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0),
           $urandom_range(0, 7) == 0, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable integer clock divider, successor to the fixed /2,/4,/8,/16 divider.
- Divides `clk` by any N in 2..2^CNT_W-1.
- Produces a divided level output and a one-cycle period tick for clock-enable use.
- Ratio changes are applied only at period boundaries, and stop always completes a full period, so `clk_out` never produces runt pulses.
- Sits in the clock-generation area, feeding slow peripherals and strobes.

Parameters:
- CNT_W, 8, width of the ratio input and internal period counter.
- RST_RATIO, 2, active ratio after reset. Must be >= 2 and <= 2^CNT_W-1.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  run request; 1 = divide, 0 = stop at the end of the current period.
- cfg_valid  input  1  new ratio offered on div_ratio.
- cfg_ready  output  1  shadow register free; a transfer occurs when cfg_valid & cfg_ready.
- div_ratio  input  CNT_W  requested divide ratio N; values 0 and 1 are clamped to 2.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the last `clk` cycle of each output period, registered.
- cur_ratio  output  CNT_W  ratio currently in effect.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, active ratio=RST_RATIO, shadow empty, clk_out=0, tick=0, cfg_ready=1, busy=0. Reset mid-period aborts immediately; no period completion.
- Definitions: H = ceil(N/2); cnt runs 0..N-1. Registered outputs take their values from the next-state cnt.
  - clk_out = (cnt < H)
  - tick = (cnt == N-1)
- IDLE: cnt held at 0, clk_out=0, tick=0.
  - Edge with en=1: go to RUN, cnt=0, clk_out=1.
  - First output period starts at that edge, i.e. one cycle of latency from en.
- RUN: each edge sets cnt = (cnt==N-1) ? 0 : cnt+1. The wrap edge N-1 -> 0 is the period boundary.
  - en=0 sampled: go to STOPPING. Counting continues unchanged.
- STOPPING: counting continues.
  - en=1 sampled before the boundary: return to RUN with no disturbance.
  - At the boundary: go to IDLE, cnt=0, clk_out=0.
- Period shapes:
  - Even N: clk_out high N/2 cycles, low N/2 cycles.
  - Odd N: clk_out high (N+1)/2 cycles, low (N-1)/2 cycles. See the optional feature for 50% odd duty.
- Configuration handshake:
  - cfg_ready = shadow empty.
  - Accepted value is clamped (values <2 become 2), then stored in the shadow.
  - In IDLE: shadow loads into the active ratio on the next edge. cur_ratio updates then.
  - In RUN/STOPPING: shadow loads at the first period boundary strictly after acceptance. An accept on a boundary edge takes effect at the following boundary.
  - Shadow load clears the shadow; cfg_ready returns to 1 on the next cycle.
  - cfg_valid with cfg_ready=0 is ignored; the value must be held by the source.
- busy = (state != IDLE).
- The tick of the final period is still emitted when entering IDLE.

Optional Feature:
- Macro CLKDIV_ODD_DUTY50_EN.
- When defined: a negedge-clk flop samples the posedge clk_out, and for odd N, clk_out = posedge_q & negedge_q. This gives a high time of exactly N/2 clk periods (50% duty).
  - Even N: output is unchanged.
  - Reset of the negedge flop: same asynchronous active-low rst, value 0.
- When undefined: no negedge logic; odd-N duty is (N+1)/2 : (N-1)/2.
- tick timing is identical in both cases.

Decomposition:
- Package clkdiv_pkg containing:
  - state enum {IDLE, RUN, STOPPING}
  - MIN_RATIO=2 constant
  - clamp function for the ratio
- One sub-module, clkdiv_halfcycle: the negedge duty-correction stage, instantiated only under CLKDIV_ODD_DUTY50_EN.
- All other logic stays in clock_divider_prog.

Test Plan:
- Reset, then en=1 with RST_RATIO=2 -> clk_out toggles 1,0,1,0 starting one cycle after en; tick on every second cycle; busy=1.
- Program N=5 in IDLE, en=1, macro undefined -> clk_out 1,1,1,0,0 repeating; tick on the 5th cycle. With the macro defined -> high 2.5 clk periods.
- Running at N=4, accept N=6 at cnt=1 -> remaining 4-cycle period completes (cnt 2,3); then 6-cycle periods 111000; cfg_ready=0 from accept until boundary+1; cur_ratio changes 4->6 at the boundary.
- Running at N=8, drop en at cnt=2 -> period continues to cnt=7 with tick; IDLE follows with clk_out=0 and busy=0. Re-raise en at cnt=5 instead -> no gap, no glitch.
- Program div_ratio=1 and div_ratio=0 -> cur_ratio=2; output identical to N=2.
- Assert rst low mid-period (N=6, cnt=3) -> clk_out, tick, busy go 0 immediately (asynchronously); cur_ratio=RST_RATIO; shadow cleared, cfg_ready=1.
